// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, issue and status signals of the multi-port register file
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ce;
    logic              ready;
    logic [ADDR_W-1:0] readreg1;
    logic [ADDR_W-1:0] readreg2;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              busy1;
    logic              busy2;
    logic              wr0_en;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr0_data;
    logic [DATA_W-1:0] wr1_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;

    modport master (
        output ce, readreg1, readreg2, wr0_en, wr1_en, wr0_addr, wr1_addr,
               wr0_data, wr1_data, issue_en, issue_addr,
        input  ready, reg1, reg2, busy1, busy2
    );

    modport slave (
        input  ce, readreg1, readreg2, wr0_en, wr1_en, wr0_addr, wr1_addr,
               wr0_data, wr1_data, issue_en, issue_addr,
        output ready, reg1, reg2, busy1, busy2
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write register file with write bypass, pending-write scoreboard
// and a post-reset clear sequence that zeroes every entry before accepting traffic.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              act, w0, w1, iss;
    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rdat [2];
    logic              rbsy [2];
    logic              hit0 [2];
    logic              hit1 [2];
    logic              ihit [2];

    assign ra[0]     = bus.readreg1;
    assign ra[1]     = bus.readreg2;
    assign bus.reg1  = rdat[0];
    assign bus.reg2  = rdat[1];
    assign bus.busy1 = rbsy[0];
    assign bus.busy2 = rbsy[1];
    assign bus.ready = state_q == READY;

    // Address 0 is filtered out of every write/issue up front when hardwired to zero.
    always_comb begin
        act = bus.ce && state_q == READY;
        w0  = act && bus.wr0_en && !(ZERO_REG != 0 && bus.wr0_addr == '0);
        w1  = act && bus.wr1_en && !(ZERO_REG != 0 && bus.wr1_addr == '0);
        iss = act && bus.issue_en && !(ZERO_REG != 0 && bus.issue_addr == '0);
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        mem_d   = mem_q;
        if (state_q == CLEAR && bus.ce) begin
            mem_d[cnt_q] = '0;
            cnt_d = cnt_q + ADDR_W'(1);
            state_d = cnt_q == ADDR_W'(DEPTH - 1) ? READY : CLEAR;
        end
        if (w0) begin
            mem_d[bus.wr0_addr]  = bus.wr0_data;
            busy_d[bus.wr0_addr] = 1'b0;
        end
        if (w1) begin
            mem_d[bus.wr1_addr]  = bus.wr1_data;
            busy_d[bus.wr1_addr] = 1'b0;
        end
        if (iss)
            busy_d[bus.issue_addr] = 1'b1;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit0[p] = w0 && bus.wr0_addr == ra[p];
            hit1[p] = w1 && bus.wr1_addr == ra[p];
            ihit[p] = iss && bus.issue_addr == ra[p];
            rdat[p] = (state_q != READY || (ZERO_REG != 0 && ra[p] == '0)) ? '0 :
                      hit1[p] ? bus.wr1_data :
                      hit0[p] ? bus.wr0_data : mem_q[ra[p]];
            rbsy[p] = state_q == READY && busy_q[ra[p]] && !((hit0[p] || hit1[p]) && !ihit[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            mem_q <= mem_d;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; DEPTH = 2^ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ce  input  1  clock enable; when 0, no state changes (reads still valid).
REQ-007 ready  output  1  high when the clear sequence is done and the file accepts writes/issues.
REQ-008 readreg1, readreg2  input  ADDR_W  read port addresses.
REQ-009 reg1, reg2  output  DATA_W  combinational read data.
REQ-010 busy1, busy2  output  1  scoreboard pending-write flag for readreg1/readreg2.
REQ-011 wr0_en, wr1_en  input  1  write-port enables.
REQ-012 wr0_addr, wr1_addr  input  ADDR_W  write addresses.
REQ-013 wr0_data, wr1_data  input  DATA_W  write data.
REQ-014 issue_en  input  1  marks issue_addr as having an outstanding write.
REQ-015 issue_addr  input  ADDR_W  destination being issued.

Function
REQ-016 States CLEAR and READY; rst forces CLEAR with clear counter = 0.
REQ-017 In CLEAR with ce=1, entry[counter] is written 0 and counter increments by 1 per cycle; with ce=0, the counter holds.
REQ-018 In CLEAR, the cycle that clears entry DEPTH-1 moves to READY on the next edge; clearing takes exactly DEPTH ce-cycles.
REQ-019 ready = 1 only in READY; in CLEAR, reg1/reg2 = 0, busy1/busy2 = 0, and wr*/issue inputs are ignored.
REQ-020 In READY with ce=1, each enabled write port stores its data at its address on the edge.
REQ-021 If both ports write the same address in one cycle, wr1 data is stored.
REQ-022 Read bypass: if an enabled write port (ce=1, READY) targets readregN in the current cycle, regN returns that write data, with wr1 taking priority over wr0; otherwise regN returns the stored entry.
REQ-023 With ZERO_REG=1: reads of address 0 return 0, writes to address 0 are discarded, and issue to address 0 is discarded; no bypass applies to address 0.
REQ-024 Scoreboard: issue_en (ce=1, READY) sets busy[issue_addr]; any enabled write to an address clears busy[address].
REQ-025 When a write and an issue target the same address in the same cycle, busy ends set.
REQ-026 busyN = busy[readregN] AND NOT (an enabled write targets readregN this cycle AND issue does not target it this cycle).
REQ-027 Read ports are independent; readreg1 = readreg2 returns identical data/busy on both.
REQ-028 Zero latency on reads; one-edge latency on writes and on busy set/clear.

Reset
REQ-029 On rst: state = CLEAR, counter = 0, all busy bits = 0, ready = 0, reg1/reg2 = 0, busy1/busy2 = 0.
REQ-030 rst overrides ce and all other inputs; rst asserted mid-clear or in READY restarts the full clear sequence.
REQ-031 Entries are not otherwise reset; they are zero only after the clear sequence completes.

Verification
REQ-032 rst 1 cycle, ce=1, DEPTH=32 -> ready stays 0 for 32 cycles and rises on cycle 33; all 32 entries read 0.
REQ-033 READY; wr0 (addr 5, 0xAAAA0000) and wr1 (addr 5, 0x5555FFFF) in the same cycle with readreg1=5 -> reg1=0x5555FFFF same cycle; it reads 0x5555FFFF afterward.
REQ-034 READY; wr0 addr 0 data 0xFFFFFFFF, issue addr 0 -> reg at address 0 reads 0, and busy for address 0 stays 0 (ZERO_REG=1).
REQ-035 READY; issue addr 7 -> busy1=1 (readreg1=7) next cycle; write addr 7 data 0x12 -> busy1=0 and reg1=0x12 that cycle; write and issue addr 7 together -> busy1 stays 1.
REQ-036 ce=0 during clear for 3 cycles -> ready rises 3 cycles late; ce=0 in READY with wr0_en=1 -> the entry is unchanged.
REQ-037 rst asserted at clear counter 10 -> the counter restarts at 0, and ready is delayed a full DEPTH cycles.
